// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - shared constants for the register bank with scoreboard
package reg_bank_pkg;

   // Default geometry of the register bank.
   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;

   // Hard-wired zero register: reads 0, ignores writes, never pending.
   localparam int ZERO_REG = 0;

endpackage

// File: rtl/reg_bank_scoreboard.sv
// rtl/reg_bank_scoreboard.sv - pending-bit scoreboard with pending count and issue-error pulse
module reg_bank_scoreboard
   import reg_bank_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NRD    = 2,
   parameter int NWR    = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [NRD*ADDR_W-1:0] rd_addr_i,
   output logic [NRD-1:0]        rd_rdy_o,
   input  logic [NWR-1:0]        wr_en_i,
   input  logic [NWR*ADDR_W-1:0] wr_addr_i,
   input  logic                  iss_en_i,
   input  logic [ADDR_W-1:0]     iss_addr_i,
   output logic [ADDR_W:0]       pend_cnt_o,
   output logic                  iss_err_o
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int CW    = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

   logic [DEPTH-1:0] pend_q, pend_d;
   logic [DEPTH-1:0] wr_hit;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             err_q, err_d;

   // Registers targeted by an enabled write this cycle (the zero register never counts).
   always_comb begin
      wr_hit = '0;
      for (int j = 0; j < NWR; j++) begin
         if (wr_en_i[j] && (wr_addr_i[j*ADDR_W +: ADDR_W] != ZERO_A)) begin
            wr_hit[wr_addr_i[j*ADDR_W +: ADDR_W]] = 1'b1;
         end
      end
   end

   // Next pending state: writes clear, then an issue sets; an issue to a still-pending
   // register (no write retiring it this cycle) is rejected and flagged instead.
   always_comb begin
      pend_d = pend_q & ~wr_hit;
      err_d  = 1'b0;
      if (iss_en_i && (iss_addr_i != ZERO_A)) begin
         if (pend_q[iss_addr_i] && !wr_hit[iss_addr_i]) begin
            err_d = 1'b1;
         end else begin
            pend_d[iss_addr_i] = 1'b1;
         end
      end
      cnt_d = '0;
      for (int a = 0; a < DEPTH; a++) begin
         cnt_d = cnt_d + CW'(pend_d[a]);
      end
   end

   // Scoreboard state, count and error pulse, cleared by synchronous reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         pend_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

   // An operand is ready if it is the zero register, not pending, or being written now.
   always_comb begin
      rd_rdy_o = '0;
      for (int i = 0; i < NRD; i++) begin
         rd_rdy_o[i] = (rd_addr_i[i*ADDR_W +: ADDR_W] == ZERO_A)
                     || !pend_q[rd_addr_i[i*ADDR_W +: ADDR_W]]
                     || wr_hit[rd_addr_i[i*ADDR_W +: ADDR_W]];
      end
   end

   assign pend_cnt_o = cnt_q;
   assign iss_err_o  = err_q;

endmodule

// File: rtl/reg_bank_sb.sv
// rtl/reg_bank_sb.sv - multi-port register bank with write bypass and issue scoreboard
module reg_bank_sb
   import reg_bank_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NRD    = 2,
   parameter int NWR    = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NRD*ADDR_W-1:0] rd_addr,
   output logic [NRD*DATA_W-1:0] rd_data,
   output logic [NRD-1:0]        rd_rdy,
   input  logic [NWR-1:0]        wr_en,
   input  logic [NWR*ADDR_W-1:0] wr_addr,
   input  logic [NWR*DATA_W-1:0] wr_data,
   input  logic                  iss_en,
   input  logic [ADDR_W-1:0]     iss_addr,
   output logic [ADDR_W:0]       pend_cnt,
   output logic                  iss_err
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];

   // Writes are dropped while reset is held, so bypass and readiness must not see them
   // either; this keeps the outputs matching the cleared state during reset.
   logic [NWR-1:0] wr_en_act;
   assign wr_en_act = wr_en & {NWR{rst_n}};

   // Next storage contents; later ports overwrite earlier ones so the highest index wins.
   always_comb begin
      mem_d = mem_q;
      for (int j = 0; j < NWR; j++) begin
         if (wr_en_act[j] && (wr_addr[j*ADDR_W +: ADDR_W] != ZERO_A)) begin
            mem_d[wr_addr[j*ADDR_W +: ADDR_W]] = wr_data[j*DATA_W +: DATA_W];
         end
      end
   end

   // Storage array, cleared by synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            mem_q[k] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   // Combinational read with same-cycle write bypass (highest port wins); $0 forced to 0.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NRD; i++) begin
         rd_data[i*DATA_W +: DATA_W] = mem_q[rd_addr[i*ADDR_W +: ADDR_W]];
         for (int j = 0; j < NWR; j++) begin
            if (wr_en_act[j] && (wr_addr[j*ADDR_W +: ADDR_W] == rd_addr[i*ADDR_W +: ADDR_W])) begin
               rd_data[i*DATA_W +: DATA_W] = wr_data[j*DATA_W +: DATA_W];
            end
         end
         if (rd_addr[i*ADDR_W +: ADDR_W] == ZERO_A) begin
            rd_data[i*DATA_W +: DATA_W] = '0;
         end
      end
   end

   reg_bank_scoreboard #(
      .ADDR_W (ADDR_W),
      .NRD    (NRD),
      .NWR    (NWR)
   ) u_scoreboard (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .rd_addr_i  (rd_addr),
      .rd_rdy_o   (rd_rdy),
      .wr_en_i    (wr_en_act),
      .wr_addr_i  (wr_addr),
      .iss_en_i   (iss_en),
      .iss_addr_i (iss_addr),
      .pend_cnt_o (pend_cnt),
      .iss_err_o  (iss_err)
   );

endmodule

// File: tb/tb_reg_bank_sb.sv
// tb/tb_reg_bank_sb.sv - self-checking bench for reg_bank_sb
module tb_reg_bank_sb;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int NR    = 2;
   localparam int NW    = 2;
   localparam int DEPTH = 32;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NR*AW-1:0] rd_addr;
   logic [NR*DW-1:0] rd_data;
   logic [NR-1:0]    rd_rdy;
   logic [NW-1:0]    wr_en;
   logic [NW*AW-1:0] wr_addr;
   logic [NW*DW-1:0] wr_data;
   logic             iss_en;
   logic [AW-1:0]    iss_addr;
   logic [AW:0]      pend_cnt;
   logic             iss_err;

   int vectors    = 0;
   int miscompares = 0;

   // Reference model: register values, pending flags, last error pulse.
   logic [DW-1:0] m_mem  [DEPTH];
   bit            m_pend [DEPTH];
   bit            m_err;

   reg_bank_sb #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .NWR(NW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_rdy   (rd_rdy),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .pend_cnt (pend_cnt),
      .iss_err  (iss_err)
   );

   always #5 clk = ~clk;

   function automatic int rd_a(int p);
      return int'(rd_addr[p*AW +: AW]);
   endfunction

   function automatic bit written_now(int a);
      bit hit = 0;
      if (rst_n && a != 0)
         for (int j = 0; j < NW; j++)
            if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) hit = 1;
      return hit;
   endfunction

   function automatic logic [DW-1:0] exp_rd(int p);
      int a = rd_a(p);
      logic [DW-1:0] v = m_mem[a];
      if (a == 0) return '0;
      if (rst_n)
         for (int j = 0; j < NW; j++)
            if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) v = wr_data[j*DW +: DW];
      return v;
   endfunction

   function automatic bit exp_rdy(int p);
      int a = rd_a(p);
      return (a == 0) || !m_pend[a] || written_now(a);
   endfunction

   function automatic int exp_cnt();
      int n = 0;
      for (int a = 0; a < DEPTH; a++) n += int'(m_pend[a]);
      return n;
   endfunction

   // Apply the register-file rules to the model for the inputs present at this edge.
   task automatic model_edge();
      bit hit [DEPTH];
      bit was_pend;
      int ia;
      if (!rst_n) begin
         for (int a = 0; a < DEPTH; a++) begin m_mem[a] = '0; m_pend[a] = 0; end
         m_err = 0;
         return;
      end
      for (int a = 0; a < DEPTH; a++) hit[a] = 0;
      for (int j = 0; j < NW; j++) begin
         int wa = int'(wr_addr[j*AW +: AW]);
         if (wr_en[j] && wa != 0) begin
            m_mem[wa] = wr_data[j*DW +: DW];
            hit[wa] = 1;
         end
      end
      ia = int'(iss_addr);
      was_pend = m_pend[ia];
      for (int a = 0; a < DEPTH; a++) if (hit[a]) m_pend[a] = 0;
      m_err = 0;
      if (iss_en && ia != 0) begin
         if (was_pend && !hit[ia]) m_err = 1;
         else m_pend[ia] = 1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      wr_en = '0; wr_addr = '0; wr_data = '0; iss_en = 1'b0; iss_addr = '0;
   endtask

   task automatic set_wr(input int j, input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_en[j] = 1'b1;
      wr_addr[j*AW +: AW] = a;
      wr_data[j*DW +: DW] = d;
   endtask

   task automatic set_rd(input int p, input logic [AW-1:0] a);
      rd_addr[p*AW +: AW] = a;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; idle(); rd_addr = '0;
      tick(); tick();
      set_wr(0, 5'd3, 32'hAA); set_rd(0, 5'd3); set_rd(1, 5'd7);
      #1;
      vectors++;
      if (rd_data[0 +: DW] !== 32'd0) begin
         miscompares++; $display("FAIL reset_bypass_blocked: got %0h want 0", rd_data[0 +: DW]);
      end
      vectors++;
      if (rd_rdy !== 2'b11) begin
         miscompares++; $display("FAIL reset_rdy: got %b want 11", rd_rdy);
      end
      vectors++;
      if (pend_cnt !== 6'd0 || iss_err !== 1'b0) begin
         miscompares++; $display("FAIL reset_regs: pend_cnt %0d iss_err %b want 0 0", pend_cnt, iss_err);
      end
      tick();
      rst_n = 1'b1; idle();
      #1;
      vectors++;
      if (rd_data[0 +: DW] !== 32'd0) begin
         miscompares++; $display("FAIL reset_write_dropped: got %0h want 0", rd_data[0 +: DW]);
      end
   endtask

   task automatic test_write_read();
      idle(); set_wr(0, 5'd5, 32'd20);
      tick();
      idle(); set_rd(0, 5'd5);
      #1;
      vectors++;
      if (rd_data[0 +: DW] !== 32'd20 || rd_rdy[0] !== 1'b1) begin
         miscompares++; $display("FAIL write_read_5: data %0d rdy %b want 20 1", rd_data[0 +: DW], rd_rdy[0]);
      end
      set_wr(0, 5'd0, 32'd7); set_rd(0, 5'd0);
      tick();
      idle();
      #1;
      vectors++;
      if (rd_data[0 +: DW] !== 32'd0 || rd_rdy[0] !== 1'b1) begin
         miscompares++; $display("FAIL write_zero_reg: data %0d rdy %b want 0 1", rd_data[0 +: DW], rd_rdy[0]);
      end
   endtask

   task automatic test_bypass_collision();
      idle(); set_wr(0, 5'd8, 32'd72); set_wr(1, 5'd8, 32'd99); set_rd(1, 5'd8);
      #1;
      vectors++;
      if (rd_data[DW +: DW] !== 32'd99) begin
         miscompares++; $display("FAIL bypass_collision: got %0d want 99", rd_data[DW +: DW]);
      end
      tick();
      idle();
      #1;
      vectors++;
      if (rd_data[DW +: DW] !== 32'd99) begin
         miscompares++; $display("FAIL collision_stored: got %0d want 99", rd_data[DW +: DW]);
      end
   endtask

   task automatic test_scoreboard();
      idle(); iss_en = 1'b1; iss_addr = 5'd9;
      tick();
      idle(); set_rd(0, 5'd9);
      #1;
      vectors++;
      if (pend_cnt !== 6'd1 || rd_rdy[0] !== 1'b0) begin
         miscompares++; $display("FAIL issue_9: pend_cnt %0d rdy %b want 1 0", pend_cnt, rd_rdy[0]);
      end
      set_wr(0, 5'd9, 32'd100);
      #1;
      vectors++;
      if (rd_rdy[0] !== 1'b1 || rd_data[0 +: DW] !== 32'd100) begin
         miscompares++; $display("FAIL retire_9_same_cycle: rdy %b data %0d want 1 100", rd_rdy[0], rd_data[0 +: DW]);
      end
      tick();
      idle();
      vectors++;
      if (pend_cnt !== 6'd0) begin
         miscompares++; $display("FAIL retire_9_cnt: got %0d want 0", pend_cnt);
      end
   endtask

   task automatic test_double_issue();
      idle(); iss_en = 1'b1; iss_addr = 5'd10;
      tick();
      tick();
      vectors++;
      if (iss_err !== 1'b1 || pend_cnt !== 6'd1) begin
         miscompares++; $display("FAIL double_issue: iss_err %b pend_cnt %0d want 1 1", iss_err, pend_cnt);
      end
      iss_en = 1'b0;
      tick();
      vectors++;
      if (iss_err !== 1'b0) begin
         miscompares++; $display("FAIL err_one_cycle: got %b want 0", iss_err);
      end
      iss_en = 1'b1; iss_addr = 5'd0;
      tick();
      idle();
      vectors++;
      if (iss_err !== 1'b0 || pend_cnt !== 6'd1) begin
         miscompares++; $display("FAIL issue_zero: iss_err %b pend_cnt %0d want 0 1", iss_err, pend_cnt);
      end
   endtask

   task automatic test_issue_write();
      idle(); iss_en = 1'b1; iss_addr = 5'd11; set_wr(0, 5'd11, 32'd55);
      tick();
      idle(); set_rd(0, 5'd11);
      #1;
      vectors++;
      if (pend_cnt !== 6'd2 || iss_err !== 1'b0 || rd_data[0 +: DW] !== 32'd55 || rd_rdy[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL issue_write_11: cnt %0d err %b data %0d rdy %b want 2 0 55 0",
                  pend_cnt, iss_err, rd_data[0 +: DW], rd_rdy[0]);
      end
      iss_en = 1'b1; iss_addr = 5'd11; set_wr(1, 5'd11, 32'd66);
      tick();
      idle();
      #1;
      vectors++;
      if (pend_cnt !== 6'd2 || iss_err !== 1'b0 || rd_data[0 +: DW] !== 32'd66) begin
         miscompares++;
         $display("FAIL reissue_write_11: cnt %0d err %b data %0d want 2 0 66", pend_cnt, iss_err, rd_data[0 +: DW]);
      end
   endtask

   task automatic test_midop_reset();
      idle(); rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         iss_en = 1'b1; iss_addr = AW'(k);
         if (k == 3) set_wr(0, 5'd15, 32'd999);
         tick();
      end
      idle(); set_rd(0, 5'd15); set_rd(1, 5'd20);
      #1;
      vectors++;
      if (pend_cnt !== 6'd3 || rd_data[0 +: DW] !== 32'd999) begin
         miscompares++; $display("FAIL pre_reset: cnt %0d data %0d want 3 999", pend_cnt, rd_data[0 +: DW]);
      end
      rst_n = 1'b0; set_wr(0, 5'd15, 32'd5); set_wr(1, 5'd20, 32'd7); iss_en = 1'b1; iss_addr = 5'd4;
      tick();
      rst_n = 1'b1; idle();
      #1;
      vectors++;
      if (pend_cnt !== 6'd0 || iss_err !== 1'b0 || rd_data[0 +: DW] !== 32'd0 || rd_data[DW +: DW] !== 32'd0) begin
         miscompares++;
         $display("FAIL midop_reset: cnt %0d err %b d15 %0d d20 %0d want 0 0 0 0",
                  pend_cnt, iss_err, rd_data[0 +: DW], rd_data[DW +: DW]);
      end
   endtask

   function automatic logic [AW-1:0] rnd_addr();
      return ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
   endfunction

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rst_n = ($urandom_range(0, 39) != 0);
         for (int j = 0; j < NW; j++) begin
            wr_en[j] = ($urandom_range(0, 2) == 0);
            wr_addr[j*AW +: AW] = rnd_addr();
            wr_data[j*DW +: DW] = $urandom;
         end
         iss_en = ($urandom_range(0, 1) == 0);
         iss_addr = rnd_addr();
         for (int p = 0; p < NR; p++) rd_addr[p*AW +: AW] = rnd_addr();
         #1;
         for (int p = 0; p < NR; p++) begin
            vectors++;
            if (rd_data[p*DW +: DW] !== exp_rd(p) || rd_rdy[p] !== exp_rdy(p)) begin
               miscompares++;
               $display("FAIL rand_read c%0d p%0d a%0d: data %0h rdy %b want %0h %b",
                        c, p, rd_a(p), rd_data[p*DW +: DW], rd_rdy[p], exp_rd(p), exp_rdy(p));
            end
         end
         tick();
         vectors++;
         if (int'(pend_cnt) != exp_cnt() || iss_err !== m_err) begin
            miscompares++;
            $display("FAIL rand_state c%0d: cnt %0d err %b want %0d %b", c, pend_cnt, iss_err, exp_cnt(), m_err);
         end
      end
      rst_n = 1'b1; idle();
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_bypass_collision();
      test_scoreboard();
      test_double_issue();
      test_issue_write();
      test_midop_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/reg_bank_sb.md
REG_BANK_SB -- requirements
Module: reg_bank_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter NRD, default 2, number of read ports.
REQ-004 SHALL have parameter NWR, default 2, number of write ports.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port rd_addr  input  NRD*ADDR_W  packed read addresses; port i occupies slice i.
REQ-008 SHALL have port rd_data  output  NRD*DATA_W  packed read data, combinational.
REQ-009 SHALL have port rd_rdy  output  NRD  per-port ready: the operand is valid, not pending.
REQ-010 SHALL have port wr_en  input  NWR  per-port write enable.
REQ-011 SHALL have port wr_addr  input  NWR*ADDR_W  packed write addresses.
REQ-012 SHALL have port wr_data  input  NWR*DATA_W  packed write data.
REQ-013 SHALL have port iss_en  input  1  issue strobe; marks iss_addr pending.
REQ-014 SHALL have port iss_addr  input  ADDR_W  destination register being issued.
REQ-015 SHALL have port pend_cnt  output  ADDR_W+1  registered count of pending registers.
REQ-016 SHALL have port iss_err  output  1  registered one-cycle pulse flagging a rejected issue.

Function
REQ-017 SHALL read register 0 as 0 at all times; register 0 SHALL ignore writes and SHALL never become pending.
REQ-018 SHALL make reads combinational (zero latency) from the storage array.
REQ-019 SHALL bypass same-cycle writes: if wr_en[j] is high, wr_addr[j] equals rd_addr[i], and the address is non-zero, then rd_data[i] SHALL equal wr_data[j].
REQ-020 SHALL write storage on the rising edge for each enabled port with a non-zero address.
REQ-021 SHALL resolve two or more writes to the same address in one cycle in favour of the highest-index port, for both storage and bypass.
REQ-022 SHALL track a pending bit for each register (scoreboard); all bits clear after reset.
REQ-023 SHALL set pending[iss_addr] at the edge when iss_en is high, iss_addr is non-zero, and the register is not already pending.
REQ-024 SHALL clear pending[a] at the edge when any enabled write targets a.
REQ-025 SHALL apply issue over clear when an issue and a write hit the same address in one cycle: the register ends pending and iss_err stays 0.
REQ-026 SHALL ignore an issue to an already-pending register when no same-cycle write targets it; iss_err SHALL be 1 for exactly the next cycle and pending SHALL be unchanged.
REQ-027 SHALL treat an issue to address 0 as a no-op with no error.
REQ-028 SHALL drive rd_rdy[i] = 1 when rd_addr[i] is 0, or the register is not pending, or a same-cycle enabled write targets it.
REQ-029 SHALL keep pend_cnt equal to the population count of the pending bits after each edge; the count saturates naturally at 2**ADDR_W-1 because register 0 is never pending.
REQ-030 SHALL NOT change pending state on a write to a register that is not pending, other than the data update.

Reset
REQ-031 SHALL, when rst_n is low at a rising edge, clear all storage to 0, all pending bits to 0, pend_cnt to 0 and iss_err to 0.
REQ-032 SHALL give reset priority over simultaneous wr_en and iss_en in the same cycle, including reset asserted mid-operation.
REQ-033 SHALL keep the combinational outputs during reset consistent with the cleared state from the cycle after the reset edge.

Structure
REQ-034 SHALL place the default DATA_W and ADDR_W values and the ZERO_REG constant (0) in the shared package reg_bank_pkg.
REQ-035 SHALL implement the pending bits, pend_cnt and iss_err in one sub-module, reg_bank_scoreboard; storage and bypass SHALL stay in reg_bank_sb.

Verification
REQ-036 SHALL cover write then read: write 20 to $5 on port 0, then read $5 on next cycle gives 20 with rd_rdy=1; a write of 7 to $0 still reads 0.
REQ-037 SHALL cover bypass and collision: same cycle, port 0 writes $8=72 and port 1 writes $8=99, with read port 1 on $8; rd_data shows 99 that cycle and storage holds 99 afterwards.
REQ-038 SHALL cover the scoreboard: issue $9 gives pend_cnt=1 and rd_rdy=0 for $9; a write of $9=100 gives rd_rdy=1 in that same cycle, and pend_cnt=0 after the edge.
REQ-039 SHALL cover double issue: issue $10 twice with no write gives iss_err=1 for one cycle and pend_cnt=1; an issue to $0 gives iss_err=0 and pend_cnt unchanged.
REQ-040 SHALL cover issue plus write to $11 in the same cycle: the register ends pending, the data is updated, and iss_err=0.
REQ-041 SHALL cover mid-operation reset: with 3 pending registers and $15=999, rst_n=0 for one edge concurrent with a write gives pend_cnt=0, $15 reading 0, and the write dropped.
